// File: rtl/instr_encoder_pkg.sv
`default_nettype none
// ============================================================================
// Module   : instr_encoder_pkg
// Brief    : Shared RV32I format codes, error codes, opcode constants and the
//            sign-extension range helper used by the encoder and the
//            processor's immediate generator.
// Revision : 1.0 - initial release
// ============================================================================
package instr_encoder_pkg;

    // Instruction format codes (shared with the immediate generator)
    localparam logic [2:0] RTYPE = 3'd0;
    localparam logic [2:0] ITYPE = 3'd1;
    localparam logic [2:0] STYPE = 3'd2;
    localparam logic [2:0] BTYPE = 3'd3;
    localparam logic [2:0] UTYPE = 3'd4;
    localparam logic [2:0] JTYPE = 3'd5;

    // Sticky error codes, first failure wins
    typedef enum logic [1:0] {
        ERR_NONE  = 2'd0,
        ERR_RANGE = 2'd1,
        ERR_ALIGN = 2'd2,
        ERR_TYPE  = 2'd3
    } err_code_t;

    // Common RV32I opcodes
    localparam logic [6:0] OP_LUI    = 7'h37;
    localparam logic [6:0] OP_AUIPC  = 7'h17;
    localparam logic [6:0] OP_JAL    = 7'h6F;
    localparam logic [6:0] OP_JALR   = 7'h67;
    localparam logic [6:0] OP_BRANCH = 7'h63;
    localparam logic [6:0] OP_LOAD   = 7'h03;
    localparam logic [6:0] OP_STORE  = 7'h23;
    localparam logic [6:0] OP_IMM    = 7'h13;
    localparam logic [6:0] OP_REG    = 7'h33;

    // True when imm[31:lsb] are all equal, i.e. the value fits as a signed
    // field whose sign bit is imm[lsb].
    function automatic logic sext_fits(input logic [31:0] imm, input logic [4:0] lsb);
        logic signed [31:0] shifted;
        shifted = $signed(imm) >>> lsb;
        return (shifted == 32'sd0) || (shifted == -32'sd1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/instr_encoder_pack.sv
`default_nettype none
// ============================================================================
// Module   : instr_pack
// Brief    : Combinational RV32I field packer with immediate range and
//            alignment checks. Unused fields of each format are zero.
// Revision : 1.0 - initial release
// ============================================================================
module instr_pack
    import instr_encoder_pkg::*;
(
    input  logic [2:0]  type_i,
    input  logic [6:0]  opcode_i,
    input  logic [4:0]  rd_i,
    input  logic [4:0]  rs1_i,
    input  logic [4:0]  rs2_i,
    input  logic [2:0]  funct3_i,
    input  logic [6:0]  funct7_i,
    input  logic [31:0] imm_i,
    output logic [31:0] word_o,
    output logic        range_err_o,
    output logic        align_err_o
);

    // Format-dependent bit placement and immediate legality
    always_comb begin
        word_o      = 32'd0;
        range_err_o = 1'b0;
        align_err_o = 1'b0;
        case (type_i)
            RTYPE: begin
                word_o = {funct7_i, rs2_i, rs1_i, funct3_i, rd_i, opcode_i};
            end
            ITYPE: begin
                word_o      = {imm_i[11:0], rs1_i, funct3_i, rd_i, opcode_i};
                range_err_o = !sext_fits(imm_i, 5'd11);
            end
            STYPE: begin
                word_o      = {imm_i[11:5], rs2_i, rs1_i, funct3_i, imm_i[4:0], opcode_i};
                range_err_o = !sext_fits(imm_i, 5'd11);
            end
            BTYPE: begin
                word_o      = {imm_i[12], imm_i[10:5], rs2_i, rs1_i, funct3_i,
                               imm_i[4:1], imm_i[11], opcode_i};
                range_err_o = !sext_fits(imm_i, 5'd12);
                align_err_o = imm_i[0];
            end
            UTYPE: begin
                word_o      = {imm_i[31:12], rd_i, opcode_i};
                range_err_o = |imm_i[11:0];
            end
            JTYPE: begin
                word_o      = {imm_i[20], imm_i[10:1], imm_i[11], imm_i[19:12], rd_i, opcode_i};
                range_err_o = !sext_fits(imm_i, 5'd20);
                align_err_o = imm_i[0];
            end
            default: begin
                word_o = 32'd0;
            end
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/instr_encoder.sv
`default_nettype none
// ============================================================================
// Module   : instr_encoder
// Brief    : Sequential RV32I instruction packer. Valid/ready request in,
//            single registered output word with word address, sticky error
//            reporting and saturating emit/error counters.
// Revision : 1.0 - initial release
// ============================================================================
module instr_encoder
    import instr_encoder_pkg::*;
#(
    parameter int ADDR_W = 10,
    parameter int CNT_W  = 16
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              req_valid_i,
    output logic              req_ready_o,
    input  logic [2:0]        type_i,
    input  logic [6:0]        opcode_i,
    input  logic [4:0]        rd_i,
    input  logic [4:0]        rs1_i,
    input  logic [4:0]        rs2_i,
    input  logic [2:0]        funct3_i,
    input  logic [6:0]        funct7_i,
    input  logic [31:0]       imm_i,
    input  logic              load_addr_i,
    input  logic [ADDR_W-1:0] start_addr_i,
    input  logic              err_clr_i,
    output logic              instr_valid_o,
    input  logic              instr_ready_i,
    output logic [31:0]       instr_o,
    output logic [ADDR_W-1:0] addr_o,
    output logic              err_o,
    output logic [1:0]        err_code_o,
    output logic [CNT_W-1:0]  emit_cnt_o,
    output logic [CNT_W-1:0]  err_cnt_o
);

    logic [31:0]       packed_word;
    logic              range_err;
    logic              align_err;
    logic              type_err;
    logic              accept;
    logic              drain;
    logic              fail;
    logic              emit;
    err_code_t         new_code;
    logic [ADDR_W-1:0] nxt;
    logic [ADDR_W-1:0] acc_addr;

    instr_pack u_pack (
        .type_i      (type_i),
        .opcode_i    (opcode_i),
        .rd_i        (rd_i),
        .rs1_i       (rs1_i),
        .rs2_i       (rs2_i),
        .funct3_i    (funct3_i),
        .funct7_i    (funct7_i),
        .imm_i       (imm_i),
        .word_o      (packed_word),
        .range_err_o (range_err),
        .align_err_o (align_err)
    );

    // Ready depends only on output state, so there is no path from req_valid_i
    assign req_ready_o = !instr_valid_o || instr_ready_i;
    assign accept      = req_valid_i && req_ready_o;
    assign drain       = instr_valid_o && instr_ready_i;
    assign type_err    = (type_i > JTYPE);
    assign fail        = range_err || align_err || type_err;
    assign emit        = accept && !fail;
    assign acc_addr    = load_addr_i ? start_addr_i : nxt;

    // Error code selection: range beats alignment; an illegal type never
    // raises either of the other two
    always_comb begin
        new_code = ERR_NONE;
        if (range_err)      new_code = ERR_RANGE;
        else if (align_err) new_code = ERR_ALIGN;
        else if (type_err)  new_code = ERR_TYPE;
    end

    // Output register and next-address counter
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            instr_valid_o <= 1'b0;
            instr_o       <= 32'd0;
            addr_o        <= '0;
            nxt           <= '0;
        end else begin
            if (emit) begin
                instr_valid_o <= 1'b1;
                instr_o       <= packed_word;
                addr_o        <= acc_addr;
                nxt           <= acc_addr + ADDR_W'(1);
            end else begin
                if (drain) begin
                    instr_valid_o <= 1'b0;
                end
                if (load_addr_i) begin
                    nxt <= start_addr_i;
                end
            end
        end
    end

    // Sticky error flag/code; a new error beats a simultaneous clear
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            err_o      <= 1'b0;
            err_code_o <= ERR_NONE;
        end else if (accept && fail) begin
            err_o <= 1'b1;
            if (!err_o || err_clr_i) begin
                err_code_o <= new_code;
            end
        end else if (err_clr_i) begin
            err_o      <= 1'b0;
            err_code_o <= ERR_NONE;
        end
    end

    // Saturating emit and error counters
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            emit_cnt_o <= '0;
            err_cnt_o  <= '0;
        end else begin
            if (drain && (emit_cnt_o != {CNT_W{1'b1}})) begin
                emit_cnt_o <= emit_cnt_o + CNT_W'(1);
            end
            if (accept && fail && (err_cnt_o != {CNT_W{1'b1}})) begin
                err_cnt_o <= err_cnt_o + CNT_W'(1);
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_instr_encoder.sv
`default_nettype none
// ============================================================================
// Module   : tb_instr_encoder
// Brief    : Self-checking bench for instr_encoder. Legal requests push the
//            expected word/address into a scoreboard; a monitor pops and
//            compares on every output handshake.
// Revision : 1.0 - initial release
// ============================================================================
module tb_instr_encoder;

    localparam int ADDR_W = 10;
    localparam int CNT_W  = 16;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              req_valid = 1'b0;
    logic              req_ready;
    logic [2:0]        typ = 3'd0;
    logic [6:0]        opcode = 7'd0;
    logic [4:0]        rd = 5'd0, rs1 = 5'd0, rs2 = 5'd0;
    logic [2:0]        funct3 = 3'd0;
    logic [6:0]        funct7 = 7'd0;
    logic [31:0]       imm = 32'd0;
    logic              load_addr = 1'b0;
    logic [ADDR_W-1:0] start_addr = '0;
    logic              err_clr = 1'b0;
    logic              instr_valid;
    logic              instr_ready = 1'b0;
    logic [31:0]       instr;
    logic [ADDR_W-1:0] addr;
    logic              err;
    logic [1:0]        err_code;
    logic [CNT_W-1:0]  emit_cnt, err_cnt;

    typedef struct packed {
        logic [31:0]       word;
        logic [ADDR_W-1:0] addr;
    } exp_t;

    exp_t              sb[$];
    logic [ADDR_W-1:0] exp_nxt = '0;
    int                checks = 0;
    int                errors = 0;

    instr_encoder #(.ADDR_W(ADDR_W), .CNT_W(CNT_W)) dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .req_valid_i   (req_valid),
        .req_ready_o   (req_ready),
        .type_i        (typ),
        .opcode_i      (opcode),
        .rd_i          (rd),
        .rs1_i         (rs1),
        .rs2_i         (rs2),
        .funct3_i      (funct3),
        .funct7_i      (funct7),
        .imm_i         (imm),
        .load_addr_i   (load_addr),
        .start_addr_i  (start_addr),
        .err_clr_i     (err_clr),
        .instr_valid_o (instr_valid),
        .instr_ready_i (instr_ready),
        .instr_o       (instr),
        .addr_o        (addr),
        .err_o         (err),
        .err_code_o    (err_code),
        .emit_cnt_o    (emit_cnt),
        .err_cnt_o     (err_cnt)
    );

    always #5 clk = ~clk;

    // Output monitor: a handshake seen at the falling edge completes on the next rising edge
    always @(negedge clk) begin
        exp_t e;
        if (!rst && instr_valid && instr_ready) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL unexpected_word: got instr=%08h addr=%03h, expected no word", instr, addr);
            end else begin
                e = sb.pop_front();
                if (instr !== e.word || addr !== e.addr) begin
                    errors++;
                    $display("FAIL output_word: got instr=%08h addr=%03h, expected instr=%08h addr=%03h",
                             instr, addr, e.word, e.addr);
                end
            end
        end
    end

    task automatic drive(input logic [2:0] t, input logic [6:0] op, input logic [4:0] d,
                         input logic [4:0] s1, input logic [4:0] s2, input logic [2:0] f3,
                         input logic [6:0] f7, input logic [31:0] im,
                         input logic ld, input logic [ADDR_W-1:0] sa);
        typ = t; opcode = op; rd = d; rs1 = s1; rs2 = s2; funct3 = f3; funct7 = f7;
        imm = im; load_addr = ld; start_addr = sa; req_valid = 1'b1;
    endtask

    // Present a request, wait (bounded) for acceptance, update the address model
    task automatic send(input logic [2:0] t, input logic [6:0] op, input logic [4:0] d,
                        input logic [4:0] s1, input logic [4:0] s2, input logic [2:0] f3,
                        input logic [6:0] f7, input logic [31:0] im,
                        input logic ld, input logic [ADDR_W-1:0] sa,
                        input logic legal, input logic [31:0] exp_word);
        logic [ADDR_W-1:0] a;
        int n;
        exp_t e;
        drive(t, op, d, s1, s2, f3, f7, im, ld, sa);
        n = 0;
        @(negedge clk);
        while (!req_ready && n < 20) begin
            n++;
            @(negedge clk);
        end
        if (!req_ready) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout: got req_ready=0, expected 1 within 20 cycles");
        end
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        load_addr = 1'b0;
        if (legal) begin
            a = ld ? sa : exp_nxt;
            e.word = exp_word;
            e.addr = a;
            sb.push_back(e);
            exp_nxt = a + 1'b1;
        end else if (ld) begin
            exp_nxt = sa;
        end
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while ((sb.size() != 0 || instr_valid) && n < 50);
        checks++;
        if (sb.size() != 0 || instr_valid) begin
            errors++;
            $display("FAIL drain_timeout: got pending=%0d valid=%b, expected 0 and 0", sb.size(), instr_valid);
        end
    endtask

    task automatic pulse_clear();
        err_clr = 1'b1;
        @(posedge clk);
        #1;
        err_clr = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        checks++;
        if (instr_valid !== 1'b0 || instr !== 32'd0 || addr !== '0 || err !== 1'b0 ||
            err_code !== 2'd0 || emit_cnt !== '0 || err_cnt !== '0 || req_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_state: got v=%b i=%08h a=%03h e=%b c=%0d ec=%0d rc=%0d rdy=%b, expected all 0 and rdy=1",
                     instr_valid, instr, addr, err, err_code, emit_cnt, err_cnt, req_ready);
        end
    endtask

    task automatic test_legal();
        instr_ready = 1'b1;
        send(3'd1, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd5,          1'b0, '0, 1'b1, 32'h00500093);
        send(3'd2, 7'h23, 5'd0, 5'd1, 5'd2, 3'd2, 7'd0, 32'd8,          1'b0, '0, 1'b1, 32'h0020A423);
        send(3'd4, 7'h37, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'h12345000,   1'b0, '0, 1'b1, 32'h123452B7);
        send(3'd0, 7'h33, 5'd3, 5'd1, 5'd2, 3'd0, 7'd0, 32'hDEADBEEF,   1'b0, '0, 1'b1, 32'h002081B3);
        wait_drain();
        checks++;
        if (emit_cnt !== 16'd4) begin
            errors++;
            $display("FAIL emit_count: got %0d, expected 4", emit_cnt);
        end
    endtask

    task automatic test_branch_jump();
        send(3'd3, 7'h63, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'hFFFFFFFC, 1'b0, '0, 1'b1, 32'hFE000EE3);
        send(3'd5, 7'h6F, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'h00000800, 1'b0, '0, 1'b1, 32'h001000EF);
        wait_drain();
        checks++;
        if (emit_cnt !== 16'd6 || err !== 1'b0) begin
            errors++;
            $display("FAIL bj_count: got emit=%0d err=%b, expected 6 and 0", emit_cnt, err);
        end
    endtask

    task automatic test_errors();
        // I-type 2048 does not fit 12 signed bits
        send(3'd1, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd2048, 1'b0, '0, 1'b0, 32'd0);
        checks++;
        if (err !== 1'b1 || err_code !== 2'd1 || err_cnt !== 16'd1 || instr_valid !== 1'b0) begin
            errors++;
            $display("FAIL range_err: got err=%b code=%0d cnt=%0d valid=%b, expected 1 1 1 0",
                     err, err_code, err_cnt, instr_valid);
        end
        // Next legal word lands at the unchanged address (6)
        send(3'd1, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd5, 1'b0, '0, 1'b1, 32'h00500093);
        // B offset 6 is legal; sticky code stays 1
        send(3'd3, 7'h63, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd6, 1'b0, '0, 1'b1, 32'h00000363);
        // B offset 5 is misaligned; first code is kept
        send(3'd3, 7'h63, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd5, 1'b0, '0, 1'b0, 32'd0);
        checks++;
        if (err_code !== 2'd1 || err_cnt !== 16'd2) begin
            errors++;
            $display("FAIL sticky_code: got code=%0d cnt=%0d, expected 1 and 2", err_code, err_cnt);
        end
        wait_drain();
        pulse_clear();
        checks++;
        if (err !== 1'b0 || err_code !== 2'd0) begin
            errors++;
            $display("FAIL err_clear: got err=%b code=%0d, expected 0 0", err, err_code);
        end
        // Misaligned J after clear gives code 2
        send(3'd5, 7'h6F, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd3, 1'b0, '0, 1'b0, 32'd0);
        checks++;
        if (err !== 1'b1 || err_code !== 2'd2 || err_cnt !== 16'd3) begin
            errors++;
            $display("FAIL align_err: got err=%b code=%0d cnt=%0d, expected 1 2 3", err, err_code, err_cnt);
        end
        // Clear together with an illegal type: the new error wins
        err_clr = 1'b1;
        send(3'd6, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd0, 1'b0, '0, 1'b0, 32'd0);
        err_clr = 1'b0;
        checks++;
        if (err !== 1'b1 || err_code !== 2'd3 || err_cnt !== 16'd4) begin
            errors++;
            $display("FAIL clr_vs_err: got err=%b code=%0d cnt=%0d, expected 1 3 4", err, err_code, err_cnt);
        end
        pulse_clear();
        // J offset out of range and odd: range has priority
        send(3'd5, 7'h6F, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'h00100001, 1'b0, '0, 1'b0, 32'd0);
        checks++;
        if (err_code !== 2'd1 || emit_cnt !== 16'd8) begin
            errors++;
            $display("FAIL priority: got code=%0d emit=%0d, expected 1 and 8", err_code, emit_cnt);
        end
        pulse_clear();
    endtask

    task automatic test_back_to_back();
        logic [ADDR_W-1:0] a_addr;
        exp_t e;
        instr_ready = 1'b0;
        a_addr = exp_nxt;
        send(3'd1, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd5, 1'b0, '0, 1'b1, 32'h00500093);
        drive(3'd4, 7'h37, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'h12345000, 1'b0, '0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if (instr_valid !== 1'b1 || instr !== 32'h00500093 || addr !== a_addr || req_ready !== 1'b0) begin
                errors++;
                $display("FAIL stall_%0d: got v=%b i=%08h a=%03h rdy=%b, expected 1 00500093 %03h 0",
                         i, instr_valid, instr, addr, req_ready, a_addr);
            end
        end
        @(posedge clk);
        #1;
        instr_ready = 1'b1;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        e.word = 32'h123452B7;
        e.addr = a_addr + 1'b1;
        sb.push_back(e);
        exp_nxt = a_addr + 2'd2;
        checks++;
        if (instr_valid !== 1'b1 || instr !== 32'h123452B7 || addr !== e.addr) begin
            errors++;
            $display("FAIL no_bubble: got v=%b i=%08h a=%03h, expected 1 123452B7 %03h",
                     instr_valid, instr, addr, e.addr);
        end
        wait_drain();
    endtask

    task automatic test_wrap();
        instr_ready = 1'b1;
        send(3'd1, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd5, 1'b1, 10'h3FF, 1'b1, 32'h00500093);
        checks++;
        if (addr !== 10'h3FF) begin
            errors++;
            $display("FAIL load_addr: got addr=%03h, expected 3ff", addr);
        end
        send(3'd2, 7'h23, 5'd0, 5'd1, 5'd2, 3'd2, 7'd0, 32'd8, 1'b0, '0, 1'b1, 32'h0020A423);
        checks++;
        if (addr !== 10'h000) begin
            errors++;
            $display("FAIL addr_wrap: got addr=%03h, expected 000", addr);
        end
        wait_drain();
    endtask

    task automatic test_reset_mid();
        instr_ready = 1'b0;
        send(3'd4, 7'h37, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'h12345000, 1'b0, '0, 1'b1, 32'h123452B7);
        rst = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if (instr_valid !== 1'b0 || instr !== 32'd0 || addr !== '0 || err !== 1'b0 ||
            err_code !== 2'd0 || emit_cnt !== '0 || err_cnt !== '0) begin
            errors++;
            $display("FAIL mid_reset: got v=%b i=%08h a=%03h e=%b c=%0d ec=%0d rc=%0d, expected all 0",
                     instr_valid, instr, addr, err, err_code, emit_cnt, err_cnt);
        end
        instr_ready = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        void'(sb.pop_back());
        exp_nxt = '0;
        // Address counter restarts at 0 after reset
        send(3'd1, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd5, 1'b0, '0, 1'b1, 32'h00500093);
        wait_drain();
        checks++;
        if (emit_cnt !== 16'd1) begin
            errors++;
            $display("FAIL post_reset_count: got %0d, expected 1", emit_cnt);
        end
    endtask

    initial begin
        test_reset();
        test_legal();
        test_branch_jump();
        test_errors();
        test_back_to_back();
        test_wrap();
        test_reset_mid();
        repeat (2) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/instr_encoder.md
# instr_encoder

Sequential RV32I instruction packer: accepts decoded instruction fields plus a 32-bit immediate over a valid/ready handshake, range-checks the immediate for the instruction format, and emits the packed 32-bit instruction word with a word address. It is the inverse of the processor's immediate-extraction path. Typical users are the boot/program loader and the bench, which write the output stream straight into instruction memory.

## Interface
Parameters:
- ADDR_W, 10, word-address width of the output address counter
- CNT_W, 16, width of the emitted and error counters

Ports:
- clk_i  in  1  clock; all state updates on the rising edge
- rst_i  in  1  synchronous, active-high reset
- req_valid_i  in  1  request fields valid
- req_ready_o  out  1  encoder can accept a request this cycle
- type_i  in  3  format code: R=0, I=1, S=2, B=3, U=4, J=5; 6 and 7 are illegal
- opcode_i  in  7  opcode, placed verbatim in bits [6:0]
- rd_i, rs1_i, rs2_i  in  5 each  register fields
- funct3_i  in  3;  funct7_i  in  7
- imm_i  in  32  full sign-extended immediate value, byte offset for B and J
- load_addr_i  in  1  load the address counter from start_addr_i
- start_addr_i  in  ADDR_W  new start word address
- err_clr_i  in  1  clear err_o and err_code_o
- instr_valid_o  out  1  instr_o and addr_o valid
- instr_ready_i  in  1  consumer accepts the word
- instr_o  out  32  packed instruction
- addr_o  out  ADDR_W  word address for instr_o
- err_o  out  1  sticky error flag
- err_code_o  out  2  first error: 1 = immediate out of range, 2 = misaligned B/J, 3 = illegal type
- emit_cnt_o, err_cnt_o  out  CNT_W  saturating counters

## Operation
- A request is accepted when req_valid_i && req_ready_o.
- req_ready_o = !instr_valid_o || instr_ready_i. This gives one output register, full throughput, and no combinational path from req_valid_i.
- Packing, with unused fields forced to 0:
  - R: funct7, rs2, rs1, funct3, rd, opcode. imm_i is ignored.
  - I: imm[11:0], rs1, funct3, rd, opcode.
  - S: imm[11:5], rs2, rs1, funct3, imm[4:0], opcode.
  - B: imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode.
  - U: imm[31:12], rd, opcode.
  - J: imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode.
- Range checks:
  - I/S: imm[31:11] all equal.
  - B: imm[31:12] all equal.
  - J: imm[31:20] all equal.
  - U: imm[11:0] == 0.
  - Any failure gives code 1.
- Alignment check: B/J with imm[0] = 1 gives code 2. Code 1 takes priority over code 2.
- A failing request is still consumed, but it does not emit a word, does not advance the address, and increments err_cnt_o.
  - err_o is set on the first failure.
  - err_code_o keeps the first code until cleared.
- Address: a next-address counter nxt.
  - At acceptance, addr_o <= (load_addr_i ? start_addr_i : nxt), and nxt <= that value + 1, wrapping modulo 2^ADDR_W.
  - load_addr_i without an acceptance sets nxt <= start_addr_i.
  - A pending output word keeps its address.
- emit_cnt_o increments on each output handshake. Both counters saturate at all-ones.

## Timing
- Reset values: instr_valid_o=0, instr_o=0, addr_o=0, nxt=0, err_o=0, err_code_o=0, both counters 0.
- req_ready_o is 1 one cycle after reset.
- Latency: a word accepted at edge N has instr_valid_o=1 after edge N. It holds stable (instr_o, addr_o) until the edge where instr_ready_i=1.
- Simultaneous drain and accept: the new word replaces the old one at the same edge, with no bubble.
- An erroring acceptance that coincides with a drain leaves instr_valid_o=0 after the edge.
- err_clr_i together with a new error: the error wins, and err_code_o takes the new code.
- Reset mid-stream discards the pending word. rst_i overrides every other input.

## Structure
- Shared package: type codes (RTYPE..JTYPE), the err_code enum, and opcode constants. The processor's immediate generator uses the same type codes.
- Natural sub-module: instr_pack. It is combinational: fields and immediate in; word, range_err and align_err out.
- This file holds only the handshake, address and counter logic.

## Test plan
- Encode four legal requests:
  - addi x1,x0,5 (I, opcode 0x13, imm 5) -> 0x00500093
  - sw x2,8(x1) (S, 0x23, f3 2) -> 0x0020A423
  - lui x5 (U, 0x37, imm 0x12345000) -> 0x123452B7
  - all with instr_ready_i=1 -> addr_o 0,1,2,3 and emit_cnt_o=4
- beq x0,x0,-4 (B, 0x63, imm 0xFFFFFFFC) -> 0xFE000EE3.
  - jal x1,2048 (J, 0x6F, imm 0x800) -> 0x001000EF.
- I-type imm 2048 -> no word, err_o=1, err_code_o=1, err_cnt_o=1, next word at the unchanged address.
  - B imm 6 -> err_code_o stays 1.
  - err_clr_i -> 0.
- Backpressure:
  - Hold instr_ready_i=0 for 3 cycles -> instr_o and addr_o stable and req_ready_o=0.
  - Release with a new request valid -> back-to-back words, no bubble.
- load_addr_i with start_addr_i=0x3FF in the same cycle as an acceptance -> addr_o=0x3FF. The next word gets addr_o=0x000 (wrap).
- Assert rst_i while instr_valid_o=1 -> all outputs return to reset values on the next edge, and the pending word is never handshaken.
